// File: rtl/lab_10_2_2_tx.sv
// lab_10_2_2_tx: buffered return-to-zero command transmitter for the lab 10 receiver
module lab_10_2_2_tx #(
    parameter int HOLD  = 1,
    parameter int GAP   = 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    input  logic [1:0]               cmd,
    output logic                     cmd_ready,
    output logic [1:0]               code,
    output logic                     busy,
    output logic                     mirror,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PW   = $clog2(DEPTH);
    localparam int LW   = PW + 1;
    localparam int MAXC = (HOLD > GAP) ? HOLD : GAP;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      code_q, code_d;
    logic            mirror_q, mirror_d;
    logic [PW-1:0]   wp_q, wp_d, rp_q, rp_d;
    logic [LW-1:0]   level_q, level_d;
    logic [1:0]      mem_q [DEPTH];
    logic            push, pop;

    assign cmd_ready = (level_q != LW'(DEPTH)) && !reset;
    assign push      = cmd_valid && cmd_ready && (cmd != 2'b00);
    assign code      = code_q;
    assign mirror    = mirror_q;
    assign level     = level_q;
    assign busy      = (state_q != S_IDLE) || (level_q != '0);

    // Symbol sequencing: pop into SEND, hold HOLD cycles, then GAP cycles of 00
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        mirror_d = mirror_q;
        pop      = 1'b0;
        case (state_q)
            S_IDLE: pop = level_q != '0;
            S_SEND: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    code_d   = 2'b00;
                    cnt_d    = CW'(GAP - 1);
                    mirror_d = (code_q == 2'b01) ? 1'b0 : (code_q == 2'b11) ? 1'b1 : ~mirror_q;
                    state_d  = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    pop     = level_q != '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) begin
            code_d  = mem_q[rp_q];
            cnt_d   = CW'(HOLD - 1);
            state_d = S_SEND;
        end
    end

    // FIFO pointer and occupancy bookkeeping
    always_comb begin
        wp_d    = push ? wp_q + PW'(1) : wp_q;
        rp_d    = pop ? rp_q + PW'(1) : rp_q;
        level_d = level_q + LW'(push) - LW'(pop);
    end

    // State registers; reset discards queued commands and any symbol in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            code_q   <= 2'b00;
            mirror_q <= 1'b0;
            wp_q     <= '0;
            rp_q     <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            mirror_q <= mirror_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            level_q  <= level_d;
        end
    end

    // FIFO storage; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= cmd;
    end
endmodule

// File: tb/tb_lab_10_2_2_tx.sv
// tb_lab_10_2_2_tx: scoreboard bench with a receiver reference model
module tb_lab_10_2_2_tx;
    localparam int H = 3;
    localparam int G = 2;
    localparam int D = 4;
    localparam int N = 8192;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic cmd_ready, busy, mirror;
    logic [1:0] code;
    logic [$clog2(D):0] level;

    lab_10_2_2_tx #(.HOLD(H), .GAP(G), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_ready(cmd_ready), .code(code), .busy(busy), .mirror(mirror), .level(level)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int wr = 0, rd = 0, zr = 1000, run = 0, plev = 0, peak = 0, lvl_m;
    logic rst_edge = 1'b0, started = 1'b0, rx = 1'b0, win = 1'b0, win_p = 1'b0;
    logic [1:0] prev = 2'b00, cur;
    logic [1:0] exp_a [N];

    task automatic chk(input string n, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", n, a, e, $time);
        end
    endtask

    // Stimulus side of the scoreboard: record every command the block must accept
    always @(posedge clk) begin
        rst_edge = reset;
        if (!reset && cmd_valid && cmd != 2'b00 && (wr - rd) != D) begin
            exp_a[wr % N] = cmd;
            wr++;
        end
    end

    // Monitor: compares line code, mirror, level, busy and ready against the model
    always @(negedge clk) begin
        if (rst_edge) begin
            chk("rst_code", code, 0);
            chk("rst_level", level, 0);
            chk("rst_mirror", mirror, 0);
            chk("rst_busy", busy, 0);
            chk("rst_ready", cmd_ready, !reset);
            rd = wr; rx = 1'b0; zr = 1000; run = 0; prev = 2'b00; plev = 0; started = 1'b1;
        end else if (started) begin
            cur = code;
            if (prev != 2'b00 && cur != 2'b00) begin
                chk("nz_to_nz", cur, prev);
                run++;
            end else if (prev == 2'b00 && cur != 2'b00) begin
                chk("gap_len", zr < G ? zr : G, G);
                chk("pop_early", plev != 0, 1);
                if (rd < wr) begin
                    chk("symbol", cur, exp_a[rd % N]);
                    rd++;
                end
                run = 1;
            end else if (prev != 2'b00 && cur == 2'b00) begin
                chk("hold_len", run, H);
                rx = (prev == 2'b01) ? 1'b0 : (prev == 2'b11) ? 1'b1 : ~rx;
                zr = 1;
            end else begin
                chk("stall", (zr >= G && plev != 0), 0);
                zr = (zr < 1000) ? zr + 1 : zr;
            end
            lvl_m = wr - rd;
            chk("mirror", mirror, rx);
            chk("level", level, lvl_m);
            chk("busy", busy, (cur != 2'b00 || zr <= G || lvl_m != 0));
            chk("ready", cmd_ready, (!reset && lvl_m != D));
            prev = cur;
            plev = lvl_m;
            if (win) peak = (int'(level) > peak) ? int'(level) : peak;
            if (win_p && !win) chk("level_peak", peak, 3);
            win_p = win;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] c);
        cmd_valid = 1'b1;
        cmd = c;
        step();
        cmd_valid = 1'b0;
        cmd = 2'b00;
    endtask

    initial begin
        int n;
        logic [1:0] pc;
        repeat (2) step();
        reset = 1'b0;
        step();
        send(2'b11);
        repeat (12) step();
        win = 1'b1;
        send(2'b11); send(2'b10); send(2'b10); send(2'b01);
        repeat (40) step();
        win = 1'b0;
        step();
        cmd_valid = 1'b1;
        cmd = 2'b10;
        repeat (10) step();
        cmd_valid = 1'b0;
        cmd = 2'b00;
        repeat (40) step();
        send(2'b00); send(2'b01);
        repeat (15) step();
        send(2'b11); send(2'b11); send(2'b10);
        n = (code != 2'b00) ? 1 : 0;
        pc = code;
        for (int k = 0; k < 100 && n < 2; k++) begin
            step();
            if (pc == 2'b00 && code != 2'b00) n++;
            pc = code;
        end
        if (n < 2) begin
            $display("FAIL mid_reset_wait got=%0d want=2", n);
            $fatal(1);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (6) step();
        for (int k = 0; k < 1000; k++) begin
            cmd_valid = $urandom_range(0, 3) != 0;
            cmd = 2'($urandom_range(0, 3));
            reset = $urandom_range(0, 399) == 0;
            step();
        end
        cmd_valid = 1'b0;
        cmd = 2'b00;
        reset = 1'b0;
        for (int k = 0; k < 300 && busy; k++) step();
        if (busy) begin
            $display("FAIL drain got=busy want=idle");
            $fatal(1);
        end
        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
